// File: rtl/api_nonce_unpack.sv
// Reassembles 4-word chip result records from the rx FIFO and forwards nonce-valid ones as 3-word packets.
// Optional duplicate suppression of the last forwarded nonce is compiled in with API_DUP_FILTER_EN.
module api_nonce_unpack #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr_cnt,
    input  logic [8:0]       rx_fifo_data_count,
    output logic             rx_fifo_rd_en,
    input  logic [31:0]      rx_fifo_dout,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [31:0]      out_dat,
    output logic             out_last,
    output logic [CNT_W-1:0] nonce_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam int         REC_WORDS = 4;
    localparam logic [8:0] REC_CNT   = 9'(REC_WORDS);
    localparam logic [2:0] LAST_RD   = 3'(REC_WORDS - 1);
    localparam logic [2:0] LAST_CAP  = 3'(REC_WORDS);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CHK, S_SEND, S_DROP} state_t;

    state_t            state_r, state_s;
    logic [2:0]        rcnt_r, rcnt_s;
    logic [1:0]        idx_r, idx_s;
    logic [31:0]       w0_r, w0_s, w1_r, w1_s, w2_r, w2_s;
    logic              rd_en_r, rd_en_s;
    logic              out_vld_r, out_vld_s;
    logic [31:0]       out_dat_r, out_dat_s;
    logic              out_last_r, out_last_s;
    logic [CNT_W-1:0]  nonce_cnt_r, nonce_cnt_s, drop_cnt_r, drop_cnt_s;
    logic              busy_r, busy_s;
    logic              inc_nonce_s, inc_drop_s;
    logic              dup_s;

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
        if (clr) begin
            sat_next = {CNT_W{1'b0}};
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            sat_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_next = cnt;
        end
    endfunction

`ifdef API_DUP_FILTER_EN
    logic [47:0] hist_r, hist_s;
    logic        hist_vld_r, hist_vld_s;

    assign dup_s = hist_vld_r && (hist_r == {w0_r[31:16], w1_r});

    // History of the last forwarded {chip_id, ch_id, nonce}; clear has priority over update
    always_comb begin
        hist_s     = hist_r;
        hist_vld_s = hist_vld_r;
        if (clr_cnt) begin
            hist_vld_s = 1'b0;
        end else if (inc_nonce_s) begin
            hist_s     = {w0_r[31:16], w1_r};
            hist_vld_s = 1'b1;
        end else begin
            hist_vld_s = hist_vld_r;
        end
    end

    // History registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_r     <= 48'd0;
            hist_vld_r <= 1'b0;
        end else begin
            hist_r     <= hist_s;
            hist_vld_r <= hist_vld_s;
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // Next-state and next-output logic; rd_en is registered so it aligns with the READ counter
    always_comb begin
        state_s     = state_r;
        rcnt_s      = rcnt_r;
        idx_s       = idx_r;
        w0_s        = w0_r;
        w1_s        = w1_r;
        w2_s        = w2_r;
        rd_en_s     = 1'b0;
        out_vld_s   = out_vld_r;
        out_dat_s   = out_dat_r;
        out_last_s  = out_last_r;
        inc_nonce_s = 1'b0;
        inc_drop_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (enable && (rx_fifo_data_count >= REC_CNT)) begin
                    state_s = S_READ;
                    rcnt_s  = 3'd0;
                    rd_en_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                rd_en_s = (rcnt_r < LAST_RD);
                rcnt_s  = rcnt_r + 3'd1;
                // Word k arrives one cycle after its strobe; the reserved 4th word is dropped
                case (rcnt_r)
                    3'd1:    w0_s = rx_fifo_dout;
                    3'd2:    w1_s = rx_fifo_dout;
                    3'd3:    w2_s = rx_fifo_dout;
                    default: w0_s = w0_r;
                endcase
                if (rcnt_r == LAST_CAP) begin
                    state_s = S_CHK;
                end else begin
                    state_s = S_READ;
                end
            end
            S_CHK: begin
                if (w0_r[0] && !dup_s) begin
                    state_s    = S_SEND;
                    idx_s      = 2'd0;
                    out_vld_s  = 1'b1;
                    out_dat_s  = w0_r;
                    out_last_s = 1'b0;
                end else begin
                    state_s = S_DROP;
                end
            end
            S_SEND: begin
                if (out_rdy) begin
                    if (idx_r == 2'd2) begin
                        state_s     = S_IDLE;
                        out_vld_s   = 1'b0;
                        out_last_s  = 1'b0;
                        inc_nonce_s = 1'b1;
                    end else begin
                        idx_s      = idx_r + 2'd1;
                        out_dat_s  = (idx_r == 2'd0) ? w1_r : w2_r;
                        out_last_s = (idx_r == 2'd1);
                    end
                end else begin
                    out_vld_s = 1'b1;
                end
            end
            S_DROP: begin
                inc_drop_s = 1'b1;
                state_s    = S_IDLE;
            end
            default: begin
                state_s    = S_IDLE;
                out_vld_s  = 1'b0;
                out_last_s = 1'b0;
            end
        endcase
        nonce_cnt_s = sat_next(nonce_cnt_r, inc_nonce_s, clr_cnt);
        drop_cnt_s  = sat_next(drop_cnt_r, inc_drop_s, clr_cnt);
        busy_s      = (state_s != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            rcnt_r      <= 3'd0;
            idx_r       <= 2'd0;
            w0_r        <= 32'd0;
            w1_r        <= 32'd0;
            w2_r        <= 32'd0;
            rd_en_r     <= 1'b0;
            out_vld_r   <= 1'b0;
            out_dat_r   <= 32'd0;
            out_last_r  <= 1'b0;
            nonce_cnt_r <= {CNT_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rcnt_r      <= rcnt_s;
            idx_r       <= idx_s;
            w0_r        <= w0_s;
            w1_r        <= w1_s;
            w2_r        <= w2_s;
            rd_en_r     <= rd_en_s;
            out_vld_r   <= out_vld_s;
            out_dat_r   <= out_dat_s;
            out_last_r  <= out_last_s;
            nonce_cnt_r <= nonce_cnt_s;
            drop_cnt_r  <= drop_cnt_s;
            busy_r      <= busy_s;
        end
    end

    assign rx_fifo_rd_en = rd_en_r;
    assign out_vld       = out_vld_r;
    assign out_dat       = out_dat_r;
    assign out_last      = out_last_r;
    assign nonce_cnt     = nonce_cnt_r;
    assign drop_cnt      = drop_cnt_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_api_nonce_unpack.sv
// Bench for api_nonce_unpack: behavioural rx FIFO, record table, packet scoreboard and corner-case sequences.
module tb_api_nonce_unpack;

    logic        clk = 1'b0;
    logic        rst, enable, clr_cnt, out_rdy;
    logic [8:0]  fifo_cnt = 9'd0;
    logic        rx_fifo_rd_en;
    logic [31:0] rx_fifo_dout = 32'd0;
    logic        out_vld, out_last, busy;
    logic [31:0] out_dat;
    logic [15:0] nonce_cnt, drop_cnt;

    always #5 clk = ~clk;

    api_nonce_unpack #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_cnt(clr_cnt),
        .rx_fifo_data_count(fifo_cnt), .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_dout(rx_fifo_dout),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_last(out_last),
        .nonce_cnt(nonce_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic        fwd;
    } rec_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          rd_total = 0;
    logic [31:0] fifo_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] exp_w;
    logic [15:0] exp_nonce, exp_drop;
    rec_t        tbl[6];

    // rx FIFO model: one-cycle read latency, cleared by the shared reset
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            fifo_cnt     <= 9'd0;
            rx_fifo_dout <= 32'd0;
        end else begin
            if (rx_fifo_rd_en) begin
                rd_total++;
                if (fifo_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL fifo_underflow: rd_en seen with empty FIFO at %0t", $time);
                end else begin
                    rx_fifo_dout <= fifo_q.pop_front();
                end
            end
            fifo_cnt <= 9'(fifo_q.size());
        end
    end

    // Packet scoreboard: compare every accepted output word against the expected queue
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL out_unexpected: got last=%b dat=0x%08h, expected no word", out_last, out_dat);
            end else begin
                exp_w = exp_q.pop_front();
                if ({out_last, out_dat} !== exp_w) begin
                    tests_failed++;
                    $display("FAIL out_word: got last=%b dat=0x%08h, expected last=%b dat=0x%08h",
                             out_last, out_dat, exp_w[32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_cnt = 9'(fifo_q.size());
    endtask

    task automatic exp_rec(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic fwd);
        if (fwd) begin
            exp_q.push_back({1'b0, w0});
            exp_q.push_back({1'b0, w1});
            exp_q.push_back({1'b1, w2});
            if (exp_nonce != 16'hFFFF) exp_nonce++;
        end else begin
            if (exp_drop != 16'hFFFF) exp_drop++;
        end
    endtask

    task automatic push_rec(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic fwd);
        push_word(w0);
        push_word(w1);
        push_word(w2);
        push_word(~w0);
        exp_rec(w0, w1, w2, fwd);
    endtask

    task automatic wait_busy(input logic val, input string name);
        int n = 0;
        while (busy !== val && n < 200) begin
            tick();
            n++;
        end
        if (busy !== val) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: timeout waiting for busy=%b", name, val);
        end
    endtask

    task automatic wait_vld(input string name);
        int n = 0;
        while (out_vld !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({name, "_vld_timeout"}, {31'd0, out_vld}, 32'd1);
    endtask

    task automatic run_rec(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic fwd, input string name);
        int rd0 = rd_total;
        push_rec(w0, w1, w2, fwd);
        wait_busy(1'b1, name);
        wait_busy(1'b0, name);
        check({name, "_nonce_cnt"}, {16'd0, nonce_cnt}, {16'd0, exp_nonce});
        check({name, "_drop_cnt"}, {16'd0, drop_cnt}, {16'd0, exp_drop});
        check({name, "_rd_pulses"}, rd_total - rd0, 32'd4);
        check({name, "_pkt_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic dup_fwd;
        int   rd0;
        tbl[0] = '{32'h0102_0001, 32'hDEAD_BEEF, 32'h0000_0055, 1'b1};
        tbl[1] = '{32'h0102_0000, 32'h1111_1111, 32'h2222_2222, 1'b0};
        tbl[2] = '{32'hA5B6_0003, 32'h1234_5678, 32'h0000_0077, 1'b1};
        tbl[3] = '{32'h0000_FFFE, 32'hCAFE_F00D, 32'h0000_0001, 1'b0};
        tbl[4] = '{32'hFFFF_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        tbl[5] = '{32'h0102_0001, 32'hDEAD_BEEF, 32'h0000_0099, 1'b1};
        exp_nonce = 16'd0;
        exp_drop  = 16'd0;
        rst = 1'b1; enable = 1'b0; clr_cnt = 1'b0; out_rdy = 1'b1;
        tick();
        tick();
        check("rst_rd_en", {31'd0, rx_fifo_rd_en}, 32'd0);
        check("rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("rst_out_dat", out_dat, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_nonce_cnt", {16'd0, nonce_cnt}, 32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        enable = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_rec(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].fwd, $sformatf("tbl%0d", i));
        end

        // Back-pressure: first word must hold for 10 cycles with no extra FIFO reads
        out_rdy = 1'b0;
        push_rec(32'h0A0B_0001, 32'h0BAD_F00D, 32'h0000_1234, 1'b1);
        wait_vld("bp");
        rd0 = rd_total;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_vld", {31'd0, out_vld}, 32'd1);
            check("bp_dat", out_dat, 32'h0A0B_0001);
            check("bp_last", {31'd0, out_last}, 32'd0);
        end
        check("bp_no_rd", rd_total - rd0, 32'd0);
        out_rdy = 1'b1;
        wait_busy(1'b0, "bp");
        check("bp_nonce_cnt", {16'd0, nonce_cnt}, {16'd0, exp_nonce});
        check("bp_pkt_drained", exp_q.size(), 32'd0);

        // Partial record must not start; enable dropped mid-READ finishes the record only
        rd0 = rd_total;
        push_word(32'h0C0D_0001);
        push_word(32'h00C0_FFEE);
        push_word(32'h0000_0003);
        for (int i = 0; i < 20; i++) tick();
        check("partial_no_rd", rd_total - rd0, 32'd0);
        check("partial_idle", {31'd0, busy}, 32'd0);
        push_word(32'h0000_0000);
        exp_rec(32'h0C0D_0001, 32'h00C0_FFEE, 32'h0000_0003, 1'b1);
        wait_busy(1'b1, "en_start");
        tick();
        tick();
        enable = 1'b0;
        push_word(32'h0C0D_0001);
        push_word(32'h00C0_FFEF);
        push_word(32'h0000_0004);
        push_word(32'h0000_0000);
        wait_busy(1'b0, "en_finish");
        for (int i = 0; i < 20; i++) tick();
        check("en_off_rd_pulses", rd_total - rd0, 32'd4);
        check("en_off_fifo_left", {23'd0, fifo_cnt}, 32'd4);
        check("en_off_idle", {31'd0, busy}, 32'd0);
        check("en_off_nonce_cnt", {16'd0, nonce_cnt}, {16'd0, exp_nonce});
        check("en_off_pkt_drained", exp_q.size(), 32'd0);
        enable = 1'b1;
        exp_rec(32'h0C0D_0001, 32'h00C0_FFEF, 32'h0000_0004, 1'b1);
        wait_busy(1'b1, "en_resume");
        wait_busy(1'b0, "en_resume");
        check("en_resume_nonce_cnt", {16'd0, nonce_cnt}, {16'd0, exp_nonce});
        check("en_resume_pkt_drained", exp_q.size(), 32'd0);

        // Saturation at all-ones, then clear coincident with an increment
        force dut.drop_cnt_r = 16'hFFFF;
        tick();
        release dut.drop_cnt_r;
        exp_drop = 16'hFFFF;
        run_rec(32'h0000_0002, 32'h1, 32'h2, 1'b0, "sat");
        clr_cnt = 1'b1;
        exp_drop  = 16'd0;
        exp_nonce = 16'd0;
        push_word(32'h0000_0004);
        push_word(32'h3);
        push_word(32'h4);
        push_word(32'h5);
        wait_busy(1'b1, "clr");
        wait_busy(1'b0, "clr");
        tick();
        clr_cnt = 1'b0;
        check("clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("clr_nonce_cnt", {16'd0, nonce_cnt}, 32'd0);

        // Reset during SEND: output drops next edge, following record is intact
        out_rdy = 1'b0;
        push_rec(32'h1122_0001, 32'h9999_9999, 32'h0000_0005, 1'b1);
        wait_vld("rst_send");
        rst = 1'b1;
        tick();
        check("rst_send_vld", {31'd0, out_vld}, 32'd0);
        check("rst_send_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_nonce = 16'd0;
        exp_drop  = 16'd0;
        out_rdy = 1'b1;
        tick();
        run_rec(32'h1122_0001, 32'h9999_9999, 32'h0000_0006, 1'b1, "post_rst");

        // Same valid record twice
`ifdef API_DUP_FILTER_EN
        dup_fwd = 1'b0;
`else
        dup_fwd = 1'b1;
`endif
        run_rec(32'h3344_0001, 32'h7777_7777, 32'h0000_0008, 1'b1, "dup_first");
        run_rec(32'h3344_0001, 32'h7777_7777, 32'h0000_0008, dup_fwd, "dup_second");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
